pulse_burst_gen: RTL
====================

PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of the period and width counters.
REQ-002 Parameter BURST_W, default 16, width of the burst counter.
REQ-003 sys_clk  in  1  single clock, the 400 MHz synthesized clock; the block has only this one clock.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin a burst.
REQ-006 stop  in  1  one-cycle request to abort the running burst.
REQ-007 period  in  CNT_W  pulse period in sys_clk cycles.
REQ-008 width  in  CNT_W  high time in sys_clk cycles.
REQ-009 burst_num  in  BURST_W  number of pulses; 0 = continuous.
REQ-010 pulse_out  out  1  generated pulse train, registered.
REQ-011 busy  out  1  high while a burst runs.
REQ-012 done  out  1  one-cycle strobe when a finite burst completes.
REQ-013 cfg_err  out  1  one-cycle strobe when start is rejected.

Function
REQ-014 States: IDLE, HIGH, LOW; the state register is the only control state.
REQ-015 period, width and burst_num are latched on an accepted start; later input changes have no effect until the next start.
REQ-016 In IDLE, start is rejected when any of the following holds: period < 2, width == 0, or width >= period. A rejected start pulses cfg_err the next cycle, and the state stays IDLE.
REQ-017 Accepted start sampled at edge T: IDLE->HIGH. pulse_out=1 and busy=1 from cycle T+1.
REQ-018 HIGH lasts exactly width cycles, then moves to LOW. LOW lasts exactly period-width cycles.
REQ-019 At the end of LOW:
- if pulses remain, or the burst is continuous: LOW->HIGH with no gap cycle;
- otherwise: LOW->IDLE.
REQ-020 Finite burst: pulse_out is active over cycles T+1..T+burst_num*period. In cycle T+burst_num*period+1, done=1 and busy=0.
REQ-021 The burst counter counts completed pulses and never wraps. burst_num=2^BURST_W-1 runs to completion normally.
REQ-022 Continuous mode (burst_num=0) runs until stop or reset. done is never asserted in this mode.
REQ-023 stop sampled in HIGH or LOW: the next cycle has pulse_out=0 and busy=0, the state is IDLE, and done is not asserted.
REQ-024 start while busy is ignored: no cfg_err, and the running burst is unaffected.
REQ-025 start and stop sampled together in IDLE: stop wins, start is ignored, and cfg_err is not asserted.
REQ-026 stop in the final LOW cycle of a finite burst: stop wins, and done is not asserted.
REQ-027 stop in IDLE has no effect.
REQ-028 A new start is accepted in the cycle in which done is high, because the state is IDLE at that point.

Reset
REQ-029 sys_rst sampled high forces the following on the next edge:
- state=IDLE;
- pulse_out=0, busy=0, done=0, cfg_err=0;
- all counters and latched configuration cleared.
REQ-030 Reset mid-burst aborts immediately with no done strobe. Reset has priority over start and stop.

Structure
REQ-031 A shared package pulse_gen_pkg holds the state enumeration and the default CNT_W and BURST_W constants.
REQ-032 One sub-module, pulse_phase_cnt, is used: a loadable down-counter with a terminal-count flag, instantiated for the HIGH/LOW phase timing. The burst counter is inline.
REQ-033 All outputs are driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-034 period=4, width=1, burst_num=3, start at T -> pulse_out high at T+1, T+5, T+9; done at T+13; busy low at T+13.
REQ-035 period=3, width=2, burst_num=0, stop at T+20 -> pulse pattern 110 repeating; at T+21 pulse_out=0, busy=0, done never asserted.
REQ-036 Three rejected configurations, each with start -> cfg_err one cycle later, pulse_out stays 0:
- period=1, width=0;
- period=5, width=5;
- period=8, width=0.
REQ-037 period=6, width=3, burst_num=2, start pulsed again at T+4, and start and stop together in IDLE -> first burst unchanged, done at T+13; the simultaneous start/stop produces no activity.
REQ-038 sys_rst asserted mid-HIGH at T+2 of a period=10, width=5 burst -> at T+3 all outputs 0; a fresh start then runs normally.
REQ-039 Back-to-back burst: start in the done cycle -> second burst's pulse_out rises the following cycle, with no dead cycle beyond the done cycle.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse burst generator.
// Holds the FSM state encoding and the default counter widths used by
// pulse_burst_gen and its phase counter.
package pulse_gen_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter with a terminal-count flag, used to time the
// HIGH and LOW phases of each pulse.
// Ports:
//   clk      - clock
//   srst     - synchronous active-high reset, clears the count
//   load     - load load_val this cycle (has priority over counting)
//   load_val - value to load; the phase then lasts load_val+1 cycles
//   en       - count down while non-zero
//   tc       - high when the count is zero (last cycle of the phase)
module pulse_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse burst generator: on an accepted start, emits burst_num pulses of
// width high cycles every period cycles (burst_num = 0 runs until stop).
// Ports:
//   sys_clk   - the single clock
//   sys_rst   - synchronous active-high reset
//   start     - one-cycle request to begin a burst (ignored while busy)
//   stop      - one-cycle abort request; wins over start and over done
//   period    - pulse period in cycles, latched on accepted start
//   width     - high time in cycles, latched on accepted start
//   burst_num - pulse count, 0 = continuous, latched on accepted start
//   pulse_out - registered pulse train
//   busy      - high while a burst runs
//   done      - one-cycle strobe after a finite burst completes
//   cfg_err   - one-cycle strobe after a rejected start
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   period,
  input  logic [CNT_W-1:0]   width,
  input  logic [BURST_W-1:0] burst_num,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   period_reg;
  logic [CNT_W-1:0]   width_reg;
  logic [BURST_W-1:0] burst_num_reg;
  logic [BURST_W-1:0] pulse_cnt_reg;
  logic               pulse_out_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               cfg_err_reg;

  logic               cfg_bad;
  logic               accept;
  logic               more;
  logic               phase_tc;
  logic               phase_load;
  logic [CNT_W-1:0]   phase_val;

  assign cfg_bad = (period < CNT_W'(2)) || (width == '0) || (width >= period);
  assign accept  = (state_reg == ST_IDLE) && start && !stop && !cfg_bad;

  // Another pulse follows when continuous, or when the pulse finishing now
  // is not the last one. One extra bit keeps the +1 from wrapping at the
  // maximum burst count.
  assign more = (burst_num_reg == '0) ||
                (({1'b0, pulse_cnt_reg} + (BURST_W+1)'(1)) < {1'b0, burst_num_reg});

  // Phase reload: width-1 entering HIGH, period-width-1 entering LOW.
  always_comb begin
    phase_load = 1'b0;
    phase_val  = '0;
    if (accept) begin
      phase_load = 1'b1;
      phase_val  = width - CNT_W'(1);
    end else if (!stop && phase_tc && (state_reg == ST_HIGH)) begin
      phase_load = 1'b1;
      phase_val  = period_reg - width_reg - CNT_W'(1);
    end else if (!stop && phase_tc && (state_reg == ST_LOW) && more) begin
      phase_load = 1'b1;
      phase_val  = width_reg - CNT_W'(1);
    end
  end

  pulse_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk      (sys_clk),
    .srst     (sys_rst),
    .load     (phase_load),
    .load_val (phase_val),
    .en       (state_reg != ST_IDLE),
    .tc       (phase_tc)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= ST_IDLE;
      period_reg    <= '0;
      width_reg     <= '0;
      burst_num_reg <= '0;
      pulse_cnt_reg <= '0;
      pulse_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && !stop) begin
            if (cfg_bad) begin
              cfg_err_reg <= 1'b1;
            end else begin
              state_reg     <= ST_HIGH;
              period_reg    <= period;
              width_reg     <= width;
              burst_num_reg <= burst_num;
              pulse_cnt_reg <= '0;
              pulse_out_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (stop) begin
            state_reg     <= ST_IDLE;
            pulse_out_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end else if (phase_tc) begin
            state_reg     <= ST_LOW;
            pulse_out_reg <= 1'b0;
          end
        end
        ST_LOW: begin
          if (stop) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (phase_tc) begin
            if (more) begin
              state_reg     <= ST_HIGH;
              pulse_out_reg <= 1'b1;
              // Continuous mode never counts, so it cannot saturate or wrap.
              if (burst_num_reg != '0) begin
                pulse_cnt_reg <= pulse_cnt_reg + BURST_W'(1);
              end
            end else begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          pulse_out_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out = pulse_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign cfg_err   = cfg_err_reg;

endmodule
